// File: rtl/stream_mux_rr_if.sv
// Purpose: bundles the N:1 merge handshake (input streams plus registered output).
// Latency: n/a (wires only).
// Backpressure: carries in_ready/out_ready; the slave modport is the mux itself.
interface stream_mux_rr_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_last;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_last;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    // Producer/consumer side: drives the input streams and the output ready.
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Purpose: round-robin N:1 stream merge with whole-packet locking onto one registered output.
// Latency: 1 cycle from input transfer to out_valid; one word per cycle sustained.
// Backpressure: in_ready is offered only when the output register is empty or draining this cycle.
module stream_mux_rr #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
) (
    input logic            clk,
    input logic            rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]  lock_idx, lock_idx_nxt;
    logic [SEL_W-1:0]  grant;
    logic              grant_ok;
    logic              load_en;
    logic              in_xfer;
    logic [NUM_IN-1:0] ready;
    logic [SEL_W:0]    cand;

    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [SEL_W-1:0]  out_sel_q;

    assign load_en = !out_valid_q || bus.out_ready;

    // Grant selection: the locked source while in a packet, else first valid input from rr_ptr upward.
    always_comb begin
        grant    = rr_ptr;
        grant_ok = 1'b0;
        cand     = '0;
        if (state == LOCKED) begin
            grant    = lock_idx;
            grant_ok = 1'b1;
        end else begin
            // Walk the ring backwards so the last hit (nearest to rr_ptr) wins without a break.
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
                if (cand >= (SEL_W + 1)'(NUM_IN)) begin
                    cand = cand - (SEL_W + 1)'(NUM_IN);
                end
                if (bus.in_valid[cand[SEL_W-1:0]]) begin
                    grant    = cand[SEL_W-1:0];
                    grant_ok = 1'b1;
                end
            end
        end
    end

    // Ready is one-hot on the granted input and forced low while reset is asserted.
    always_comb begin
        ready = '0;
        if (rst_n && grant_ok) begin
            ready[grant] = load_en;
        end
        in_xfer = bus.in_valid[grant] && ready[grant];
    end

    assign bus.in_ready = ready;

    // Next state: lock on a non-last beat, release and advance the pointer past the source on its last beat.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        if (in_xfer) begin
            if (bus.in_last[grant]) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = (grant == LAST_IDX) ? '0 : grant + 1'b1;
            end else begin
                state_nxt    = LOCKED;
                lock_idx_nxt = grant;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // Output register: load on input transfer, otherwise empty it when the consumer takes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (in_xfer) begin
            out_data_q  <= bus.in_data[int'(grant) * WIDTH +: WIDTH];
            out_valid_q <= 1'b1;
            out_last_q  <= bus.in_last[grant];
            out_sel_q   <= grant;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Purpose: directed check of stream_mux_rr arbitration, packet lock, backpressure and reset.
// Latency: each table row is one clock; outputs reflect transfers from earlier rows.
// Backpressure: exercised through out_ready in the table rows.
module tb_stream_mux_rr;
    localparam int WIDTH  = 16;
    localparam int NUM_IN = 4;

    logic clk;
    logic rst_n;

    stream_mux_rr_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

    stream_mux_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [63:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ovld;
        logic [15:0] e_odat;
        logic [1:0]  e_sel;
        logic        e_olast;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [23];

    function automatic logic [63:0] pk(input logic [15:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic [3:0] vld, last, input logic [63:0] dat,
                                input logic ordy, input logic [3:0] e_rdy, input logic e_ovld,
                                input logic [15:0] e_odat, input logic [1:0] e_sel, input logic e_olast);
        vec_t v;
        v.vld = vld; v.last = last; v.dat = dat; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_odat = e_odat; v.e_sel = e_sel; v.e_olast = e_olast;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, last, input logic [63:0] dat, input logic ordy);
        bus.in_valid  = vld;
        bus.in_last   = last;
        bus.in_data   = dat;
        bus.out_ready = ordy;
    endtask

    initial begin
        // Round-robin fairness, all inputs valid with single-beat packets.
        tbl[0]  = mk(4'hF, 4'hF, pk(16'hA003, 16'hA002, 16'hA001, 16'hA000), 1, 4'b0001, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(4'hF, 4'hF, pk(16'hA003, 16'hA002, 16'hA001, 16'hA000), 1, 4'b0010, 1, 16'hA000, 0, 1);
        tbl[2]  = mk(4'hF, 4'hF, pk(16'hA003, 16'hA002, 16'hA001, 16'hA000), 1, 4'b0100, 1, 16'hA001, 1, 1);
        tbl[3]  = mk(4'hF, 4'hF, pk(16'hA003, 16'hA002, 16'hA001, 16'hA000), 1, 4'b1000, 1, 16'hA002, 2, 1);
        tbl[4]  = mk(4'hF, 4'hF, pk(16'hA003, 16'hA002, 16'hA001, 16'hA000), 1, 4'b0001, 1, 16'hA003, 3, 1);
        tbl[5]  = mk(4'h0, 4'h0, 64'h0, 1, 4'b0000, 1, 16'hA000, 0, 1);
        tbl[6]  = mk(4'h0, 4'h0, 64'h0, 1, 4'b0000, 0, 16'h0000, 0, 0);
        // Packet lock: input 2 sends three beats while input 0 stays valid.
        tbl[7]  = mk(4'b0101, 4'b0001, pk(16'h0, 16'h0021, 16'h0, 16'h0000), 1, 4'b0100, 0, 16'h0000, 0, 0);
        tbl[8]  = mk(4'b0101, 4'b0001, pk(16'h0, 16'h0022, 16'h0, 16'h0000), 1, 4'b0100, 1, 16'h0021, 2, 0);
        tbl[9]  = mk(4'b0101, 4'b0101, pk(16'h0, 16'h0023, 16'h0, 16'h0000), 1, 4'b0100, 1, 16'h0022, 2, 0);
        tbl[10] = mk(4'b0001, 4'b0001, pk(16'h0, 16'h0, 16'h0, 16'h0000), 1, 4'b0001, 1, 16'h0023, 2, 1);
        tbl[11] = mk(4'b0001, 4'b0001, pk(16'h0, 16'h0, 16'h0, 16'h0001), 1, 4'b0001, 1, 16'h0000, 0, 1);
        // Backpressure for five cycles, then drain and load in the same cycle.
        for (int i = 12; i <= 16; i++)
            tbl[i] = mk(4'b0011, 4'b0011, pk(16'h0, 16'h0, 16'h0011, 16'h0002), 0, 4'b0000, 1, 16'h0001, 0, 1);
        tbl[17] = mk(4'b0011, 4'b0011, pk(16'h0, 16'h0, 16'h0011, 16'h0002), 1, 4'b0010, 1, 16'h0001, 0, 1);
        tbl[18] = mk(4'b0001, 4'b0001, pk(16'h0, 16'h0, 16'h0, 16'h0002), 1, 4'b0001, 1, 16'h0011, 1, 1);
        // Sparse request on input 3, then pointer wrap to 0 beats a still-valid input 3.
        tbl[19] = mk(4'b1000, 4'b1000, pk(16'h0033, 16'h0, 16'h0, 16'h0), 1, 4'b1000, 1, 16'h0002, 0, 1);
        tbl[20] = mk(4'b1001, 4'b1001, pk(16'h0033, 16'h0, 16'h0, 16'h0004), 1, 4'b0001, 1, 16'h0033, 3, 1);
        tbl[21] = mk(4'h0, 4'h0, 64'h0, 1, 4'b0000, 1, 16'h0004, 0, 1);
        tbl[22] = mk(4'h0, 4'h0, 64'h0, 1, 4'b0000, 0, 16'h0000, 0, 0);

        // Reset held with every input requesting.
        rst_n = 1'b0;
        drive(4'hF, 4'hF, pk(16'hA003, 16'hA002, 16'hA001, 16'hA000), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst out_data",  32'(bus.out_data),  32'd0);
        chk("rst out_sel",   32'(bus.out_sel),   32'd0);
        chk("rst out_last",  32'(bus.out_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h0, 4'h0, 64'h0, 1);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].last, tbl[i].dat, tbl[i].ordy);
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ovld));
            if (tbl[i].e_ovld) begin
                chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].e_odat));
                chk($sformatf("row%0d out_sel", i),  32'(bus.out_sel),  32'(tbl[i].e_sel));
                chk($sformatf("row%0d out_last", i), 32'(bus.out_last), 32'(tbl[i].e_olast));
            end
        end

        // Reset while locked on input 1 (pointer is 1 here).
        @(negedge clk);
        drive(4'b0010, 4'b0000, pk(16'h0, 16'h0, 16'h0101, 16'h0), 1);
        #1;
        chk("lk beat1 in_ready", 32'(bus.in_ready), 32'b0010);
        @(negedge clk);
        drive(4'b0011, 4'b0011, pk(16'h0, 16'h0, 16'h0102, 16'h0007), 1);
        #1;
        chk("lk out_valid", 32'(bus.out_valid), 32'd1);
        chk("lk out_sel",   32'(bus.out_sel),   32'd1);
        chk("lk in_ready",  32'(bus.in_ready),  32'b0010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst in_ready", 32'(bus.in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post rst out_valid", 32'(bus.out_valid), 32'd1);
        chk("post rst out_sel",   32'(bus.out_sel),   32'd0);
        chk("post rst out_data",  32'(bus.out_data),  32'h0007);
        chk("post rst out_last",  32'(bus.out_last),  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
